// File: rtl/cac_uart_pkg.sv
// Shared definitions for the CAC UART receive path: parity modes, receiver
// state encoding and the baud-tick divider calculation.
package cac_uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Parity and its state share a name with the PARITY parameter, so states carry a prefix.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clocks per sample tick, rounded to nearest and never below one.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        longint q;
        den = baud * os;
        q   = (clk_hz + den / 2) / den;
        if (q < 1) q = 1;
        return int'(q);
    endfunction

    // Two-out-of-three vote over the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head word is presented on
// rd_data whenever rd_valid is high; a write into a full FIFO is only
// accepted when a read frees a slot in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_rd;
    logic             do_wr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_rd    = rd_en & ~empty;
    assign do_wr    = wr_en & (~full | do_rd);
    assign overflow = wr_en & full & ~rd_en;
    assign rd_valid = ~empty;
    // Force zero while empty so the output is clean out of reset.
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cac_uart_rx_fifo.sv
// CAC command UART receiver: oversampled, majority-voted frame reception with
// configurable format, feeding a FWFT FIFO and sticky error flags.
module cac_uart_rx_fifo
    import cac_uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUDRATE        = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int MSB_FIRST       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_error,
    output logic                          parity_error,
    output logic                          overrun_error,
    input  logic                          err_clr,
    output logic                          busy
);

    localparam int DIV    = calc_div(CLOCK_FREQUENCY, BAUDRATE, OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W   = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS + 1);

    localparam logic [OS_W-1:0]   SAMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   SAMP_B   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]   SAMP_C   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0]   SAMP_END = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0]  DIV_END  = DIV_W'(DIV - 1);

    rx_state_t            state;
    rx_state_t            state_nx;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 fall;
    logic [DIV_W-1:0]     div_cnt;
    logic [OS_W-1:0]      samp_cnt;
    logic                 tick;
    logic                 bit_end;
    logic                 s0;
    logic                 s1;
    logic                 vote_bit;
    logic                 vote_done;
    logic [DATA_BITS-1:0] shift;
    logic [BCNT_W-1:0]    bit_idx;
    logic                 last_data;
    logic                 par_bit;
    logic                 par_exp;
    logic                 stop_idx;
    logic                 stop_bad;
    logic                 last_stop;
    logic                 fifo_wr;
    logic                 frame_set;
    logic                 par_set;
    logic                 overrun_set;

    assign busy      = (state != ST_IDLE);
    assign fall      = rx_prev & ~rx_sync;
    assign tick      = busy && (div_cnt == DIV_END);
    assign bit_end   = tick && (samp_cnt == SAMP_END);
    assign last_data = (bit_idx == BCNT_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign par_exp   = (^shift) ^ (PARITY == PARITY_ODD);

    // Two-flop synchroniser plus a history flop for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Tick divider and per-bit sample counter; both held at zero while idle so they restart on start detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (!busy) begin
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + 1'b1;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    // Capture the three mid-bit samples and register the vote with a one-cycle done strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0        <= 1'b1;
            s1        <= 1'b1;
            vote_bit  <= 1'b1;
            vote_done <= 1'b0;
        end else begin
            vote_done <= 1'b0;
            if (tick) begin
                if (samp_cnt == SAMP_A) s0 <= rx_sync;
                if (samp_cnt == SAMP_B) s1 <= rx_sync;
                if (samp_cnt == SAMP_C) begin
                    vote_bit  <= majority3(s0, s1, rx_sync);
                    vote_done <= 1'b1;
                end
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; the end-of-frame decision is taken on the vote of the last stop bit.
    always_comb begin
        state_nx  = state;
        fifo_wr   = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) state_nx = ST_START;
            end
            ST_START: begin
                if (vote_done && vote_bit) state_nx = ST_IDLE;
                else if (bit_end)          state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data)
                    state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (vote_done && last_stop) begin
                    state_nx = ST_IDLE;
                    if (stop_bad || !vote_bit)
                        frame_set = 1'b1;
                    else if ((PARITY != PARITY_NONE) && (par_bit != par_exp))
                        par_set = 1'b1;
                    else
                        fifo_wr = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Frame datapath: data shift register, bit/stop counters, parity and stop-bit capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift    <= '0;
            bit_idx  <= '0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (vote_done) begin
                case (state)
                    ST_DATA: begin
                        if (MSB_FIRST != 0) shift <= {shift[DATA_BITS-2:0], vote_bit};
                        else                shift <= {vote_bit, shift[DATA_BITS-1:1]};
                    end
                    ST_PARITY: par_bit <= vote_bit;
                    ST_STOP:   if (!vote_bit) stop_bad <= 1'b1;
                    default: ;
                endcase
            end
            if (bit_end) begin
                if (state == ST_DATA) bit_idx <= last_data ? '0 : bit_idx + 1'b1;
                if (state == ST_STOP) stop_idx <= 1'b1;
            end
        end
    end

    // Sticky error flags; a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (frame_set)        framing_error <= 1'b1;
            else if (err_clr)     framing_error <= 1'b0;
            if (par_set)          parity_error  <= 1'b1;
            else if (err_clr)     parity_error  <= 1'b0;
            if (overrun_set)      overrun_error <= 1'b1;
            else if (err_clr)     overrun_error <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .wr_data  (shift),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .overflow (overrun_set)
    );

endmodule

// File: tb/tb_cac_uart_rx_fifo.sv
// Directed bench for cac_uart_rx_fifo: three instances cover the default
// format, 7-bit even parity and a 4-deep FIFO at 1 Mbaud / 10x oversampling.
module tb_cac_uart_rx_fifo;

    localparam int BIT_NS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       rx_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
    logic [7:0] data_a;
    logic [4:0] cnt_a;
    logic       vld_a, fe_a, pe_a, oe_a, busy_a;

    logic       rx_p = 1'b1, rd_en_p = 1'b0, clr_p = 1'b0;
    logic [6:0] data_p;
    logic [4:0] cnt_p;
    logic       vld_p, fe_p, pe_p, oe_p, busy_p;

    logic       rx_f = 1'b1, rd_en_f = 1'b0, clr_f = 1'b0;
    logic [7:0] data_f;
    logic [2:0] cnt_f;
    logic       vld_f, fe_f, pe_f, oe_f, busy_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cac_uart_rx_fifo #(
        .CLOCK_FREQUENCY(100_000_000), .BAUDRATE(1_000_000), .OVERSAMPLE(10)
    ) ua (
        .clk(clk), .rst(rst), .uart_rx(rx_a), .rd_en(rd_en_a), .rd_data(data_a),
        .rd_valid(vld_a), .fifo_count(cnt_a), .framing_error(fe_a),
        .parity_error(pe_a), .overrun_error(oe_a), .err_clr(clr_a), .busy(busy_a)
    );

    cac_uart_rx_fifo #(
        .CLOCK_FREQUENCY(100_000_000), .BAUDRATE(1_000_000), .OVERSAMPLE(10),
        .DATA_BITS(7), .PARITY(2)
    ) up (
        .clk(clk), .rst(rst), .uart_rx(rx_p), .rd_en(rd_en_p), .rd_data(data_p),
        .rd_valid(vld_p), .fifo_count(cnt_p), .framing_error(fe_p),
        .parity_error(pe_p), .overrun_error(oe_p), .err_clr(clr_p), .busy(busy_p)
    );

    cac_uart_rx_fifo #(
        .CLOCK_FREQUENCY(100_000_000), .BAUDRATE(1_000_000), .OVERSAMPLE(10),
        .FIFO_DEPTH(4)
    ) uf (
        .clk(clk), .rst(rst), .uart_rx(rx_f), .rd_en(rd_en_f), .rd_data(data_f),
        .rd_valid(vld_f), .fifo_count(cnt_f), .framing_error(fe_f),
        .parity_error(pe_f), .overrun_error(oe_f), .err_clr(clr_f), .busy(busy_f)
    );

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_f = v;
        endcase
    endtask

    // bits[0] goes on the line first; line returns high afterwards.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(sel, bits[i]);
            #(BIT_NS);
        end
        set_line(sel, 1'b1);
    endtask

    // Line order: start 0, d7..d0 (MSB first), stop.
    function automatic logic [15:0] frame8(input logic [7:0] d, input logic stop);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[7-i];
        f[9] = stop;
        return f;
    endfunction

    // Line order: start 0, d6..d0, parity bit, stop 1.
    function automatic logic [15:0] frame7p(input logic [6:0] d, input logic par);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 7; i++) f[1+i] = d[6-i];
        f[8] = par;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cyc(3);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", data_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", vld_a); end
        checks++; if (cnt_a !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt_a); end
        checks++; if ({fe_a, pe_a, oe_a, busy_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {fe_a, pe_a, oe_a, busy_a}); end
        checks++; if ({vld_p, fe_p, pe_p, oe_p, busy_p, vld_f, fe_f, pe_f, oe_f, busy_f} !== 10'd0 || cnt_p !== 5'd0 || cnt_f !== 3'd0 || data_p !== 7'd0 || data_f !== 8'd0)
            begin errors++; $display("FAIL reset_other_instances got nonzero output want all 0"); end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_basic;
        logic [7:0] exp [5];
        exp[0] = 8'h10; exp[1] = 8'h01; exp[2] = 8'h11; exp[3] = 8'h11; exp[4] = 8'h30;
        send_bits(0, frame8(8'h10, 1'b1), 10);
        wait_cyc(5);
        checks++; if (data_a !== 8'h10) begin errors++; $display("FAIL basic_first_word got %h want 10", data_a); end
        checks++; if (vld_a !== 1'b1 || cnt_a !== 5'd1) begin errors++; $display("FAIL basic_first_count got vld=%b cnt=%0d want vld=1 cnt=1", vld_a, cnt_a); end
        for (int i = 1; i < 5; i++) send_bits(0, frame8(exp[i], 1'b1), 10);
        wait_cyc(5);
        checks++; if (cnt_a !== 5'd5) begin errors++; $display("FAIL basic_count5 got %0d want 5", cnt_a); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (data_a !== exp[i]) begin errors++; $display("FAIL basic_pop%0d got %h want %h", i, data_a, exp[i]); end
            rd_en_a = 1'b1;
            @(negedge clk);
            rd_en_a = 1'b0;
        end
        checks++; if (vld_a !== 1'b0 || cnt_a !== 5'd0) begin errors++; $display("FAIL basic_drained got vld=%b cnt=%0d want vld=0 cnt=0", vld_a, cnt_a); end
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
        checks++; if (cnt_a !== 5'd0) begin errors++; $display("FAIL basic_pop_empty got cnt=%0d want 0", cnt_a); end
    endtask

    task automatic test_glitch;
        rx_a = 1'b0;
        #200;
        rx_a = 1'b1;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_set got %b want 1", busy_a); end
        #800;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear got %b want 0", busy_a); end
        wait_cyc(200);
        checks++; if (cnt_a !== 5'd0 || {fe_a, pe_a, oe_a} !== 3'b000) begin errors++; $display("FAIL glitch_no_effect got cnt=%0d flags=%b want cnt=0 flags=000", cnt_a, {fe_a, pe_a, oe_a}); end
    endtask

    task automatic test_framing;
        send_bits(0, frame8(8'hA5, 1'b0), 10);
        wait_cyc(5);
        checks++; if (fe_a !== 1'b1) begin errors++; $display("FAIL framing_flag got %b want 1", fe_a); end
        checks++; if (cnt_a !== 5'd0) begin errors++; $display("FAIL framing_no_write got cnt=%0d want 0", cnt_a); end
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL framing_clear got %b want 0", fe_a); end
    endtask

    task automatic test_parity;
        // 0x55 = 1010101: four ones, so even parity needs a 0 parity bit.
        send_bits(1, frame7p(7'h55, 1'b1), 10);
        wait_cyc(5);
        checks++; if (pe_p !== 1'b1) begin errors++; $display("FAIL parity_flag got %b want 1", pe_p); end
        checks++; if (cnt_p !== 5'd0) begin errors++; $display("FAIL parity_no_write got cnt=%0d want 0", cnt_p); end
        send_bits(1, frame7p(7'h55, 1'b0), 10);
        wait_cyc(5);
        checks++; if (data_p !== 7'h55 || vld_p !== 1'b1) begin errors++; $display("FAIL parity_good_word got %h vld=%b want 55 vld=1", data_p, vld_p); end
        checks++; if (fe_p !== 1'b0 || pe_p !== 1'b1) begin errors++; $display("FAIL parity_sticky got fe=%b pe=%b want fe=0 pe=1", fe_p, pe_p); end
    endtask

    task automatic test_overrun;
        bit seen;
        for (int i = 1; i <= 5; i++) send_bits(2, frame8(8'(i), 1'b1), 10);
        wait_cyc(5);
        checks++; if (cnt_f !== 3'd4) begin errors++; $display("FAIL overrun_count got %0d want 4", cnt_f); end
        checks++; if (oe_f !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", oe_f); end
        checks++; if (data_f !== 8'h01) begin errors++; $display("FAIL overrun_head got %h want 01", data_f); end
        clr_f = 1'b1;
        rd_en_f = 1'b1;
        wait_cyc(4);
        clr_f = 1'b0;
        rd_en_f = 1'b0;
        checks++; if (cnt_f !== 3'd0 || oe_f !== 1'b0) begin errors++; $display("FAIL overrun_drain got cnt=%0d oe=%b want 0 0", cnt_f, oe_f); end
        for (int i = 0; i < 4; i++) send_bits(2, frame8(8'h11 + 8'(i), 1'b1), 10);
        seen = 1'b0;
        fork
            send_bits(2, frame8(8'h15, 1'b1), 10);
            begin
                for (int c = 0; c < 2000 && !seen; c++) begin
                    @(negedge clk);
                    if (uf.fifo_wr === 1'b1) begin
                        seen = 1'b1;
                        rd_en_f = 1'b1;
                        @(negedge clk);
                        rd_en_f = 1'b0;
                    end
                end
            end
        join
        checks++; if (!seen) begin errors++; $display("FAIL overrun_write_strobe got none want one within 2000 cycles"); end
        wait_cyc(5);
        checks++; if (cnt_f !== 3'd4 || oe_f !== 1'b0) begin errors++; $display("FAIL simul_rw got cnt=%0d oe=%b want cnt=4 oe=0", cnt_f, oe_f); end
        checks++; if (data_f !== 8'h12) begin errors++; $display("FAIL simul_rw_head got %h want 12", data_f); end
        rd_en_f = 1'b1;
        wait_cyc(3);
        rd_en_f = 1'b0;
        checks++; if (data_f !== 8'h15 || cnt_f !== 3'd1) begin errors++; $display("FAIL simul_rw_tail got %h cnt=%0d want 15 cnt=1", data_f, cnt_f); end
    endtask

    task automatic test_reset_mid;
        send_bits(0, frame8(8'h77, 1'b1), 10);
        wait_cyc(5);
        // Start a frame 0x81 and stop part-way through the third data bit.
        send_bits(0, frame8(8'h81, 1'b1), 3);
        rx_a = 1'b0;
        #500;
        checks++; if (busy_a !== 1'b1 || vld_a !== 1'b1) begin errors++; $display("FAIL midreset_pre got busy=%b vld=%b want 1 1", busy_a, vld_a); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({busy_a, vld_a, fe_a, pe_a, oe_a} !== 5'b00000 || cnt_a !== 5'd0 || data_a !== 8'h00)
            begin errors++; $display("FAIL midreset_outputs got busy=%b vld=%b cnt=%0d data=%h want all 0", busy_a, vld_a, cnt_a, data_a); end
        rx_a = 1'b1;
        @(negedge clk);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        send_bits(0, frame8(8'h3C, 1'b1), 10);
        wait_cyc(5);
        checks++; if (data_a !== 8'h3C || cnt_a !== 5'd1) begin errors++; $display("FAIL midreset_next_frame got %h cnt=%0d want 3c cnt=1", data_a, cnt_a); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_framing;
        test_parity;
        test_overrun;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
